// File: rtl/bram_word_buffer.sv
// bram_word_buffer: in-order word buffer between the DRAM byte-packer and the
// PE-array loader. Words land in a DEPTH-entry memory and are streamed out
// through a one-word output register with a valid/ready handshake.
// Optional build macro: BRAM_BUF_OVF_FLAG_EN enables the sticky overflow flag
// (ovf); without it ovf is tied low and no error logic is built.
`timescale 1ns/1ps
module bram_word_buffer #(
   parameter int WIDTH  = 163,
   parameter int DEPTH  = 256,
   parameter int ADDR_W = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [WIDTH-1:0]  wr_data,
   input  logic              wr_en,
   input  logic              flush,
   output logic [WIDTH-1:0]  rd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   count,
   output logic              ovf
);

   localparam logic [ADDR_W:0] DEPTH_CNT = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] ONE       = (ADDR_W+1)'(1);

   // Storage array; contents are deliberately never reset.
   logic [WIDTH-1:0] mem_q [DEPTH];

   logic [ADDR_W:0]  wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]  rd_ptr_q, rd_ptr_d;
   logic [ADDR_W:0]  count_q, count_d;
   logic [WIDTH-1:0] rd_data_q;
   logic             rd_valid_q, rd_valid_d;
   logic             full_q, full_d;
   logic             empty_q, empty_d;

   logic             wr_acc;
   logic             pop_acc;
   logic             mem_has_word;
   logic             load;

   // Handshake decode and next-state computation for pointers, count and flags.
   always_comb begin
      wr_acc       = wr_en & ~full_q & ~flush;
      pop_acc      = rd_valid_q & rd_ready;
      // Pointers carry a wrap bit, so equality means the array itself is empty.
      mem_has_word = (wr_ptr_q != rd_ptr_q);
      load         = (~rd_valid_q | pop_acc) & mem_has_word & ~flush;

      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      rd_valid_d = rd_valid_q;
      count_d    = count_q;
      full_d     = full_q;
      empty_d    = empty_q;

      if (flush) begin
         wr_ptr_d   = '0;
         rd_ptr_d   = '0;
         rd_valid_d = 1'b0;
         count_d    = '0;
         full_d     = 1'b0;
         empty_d    = 1'b1;
      end else begin
         if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + ONE;
         end
         if (load) begin
            rd_ptr_d   = rd_ptr_q + ONE;
            rd_valid_d = 1'b1;
         end else if (pop_acc) begin
            rd_valid_d = 1'b0;
         end
         // count includes the word sitting in the output register.
         count_d = count_q + (wr_acc ? ONE : '0) - (pop_acc ? ONE : '0);
         full_d  = (count_d == DEPTH_CNT);
         empty_d = (count_d == '0);
      end
   end

   // Control state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         rd_valid_q <= 1'b0;
         count_q    <= '0;
         full_q     <= 1'b0;
         empty_q    <= 1'b1;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         rd_valid_q <= rd_valid_d;
         count_q    <= count_d;
         full_q     <= full_d;
         empty_q    <= empty_d;
      end
   end

   // Memory write port; a write is only accepted when the buffer is not full.
   always_ff @(posedge clk) begin
      if (wr_acc) begin
         mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_data;
      end
   end

   // Registered read into the output register; holds its value when not reloaded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data_q <= '0;
      end else if (flush) begin
         rd_data_q <= '0;
      end else if (load) begin
         rd_data_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
   end

`ifdef BRAM_BUF_OVF_FLAG_EN
   logic ovf_q;

   // Sticky data-loss flag: a write strobe while full drops a word; only rst_n clears it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q <= 1'b0;
      end else if (wr_en & full_q) begin
         ovf_q <= 1'b1;
      end
   end

   assign ovf = ovf_q;
`else
   assign ovf = 1'b0;
`endif

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign full     = full_q;
   assign empty    = empty_q;
   assign count    = count_q;

endmodule

// File: tb/tb_bram_word_buffer.sv
// Self-checking bench for bram_word_buffer: a directed vector table, hand
// sequences for fill/drain, flush, throughput and async reset, and a random
// phase checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_bram_word_buffer;

   localparam int WIDTH  = 163;
   localparam int DEPTH  = 256;
   localparam int ADDR_W = 8;

   typedef logic [WIDTH-1:0] word_t;

`ifdef BRAM_BUF_OVF_FLAG_EN
   localparam bit OVF_EN = 1'b1;
`else
   localparam bit OVF_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   word_t           wr_data = '0;
   logic            wr_en = 1'b0;
   logic            flush = 1'b0;
   logic            rd_ready = 1'b0;
   word_t           rd_data;
   logic            rd_valid;
   logic            full;
   logic            empty;
   logic [ADDR_W:0] count;
   logic            ovf;

   always #5 clk = ~clk;

   bram_word_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst_n(rst_n), .wr_data(wr_data), .wr_en(wr_en), .flush(flush),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .full(full), .empty(empty), .count(count), .ovf(ovf)
   );

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input word_t act, input word_t exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic word_t rand_word();
      logic [191:0] t;
      t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
      return t[WIDTH-1:0];
   endfunction

   // ---------------- reference model ----------------
   // The buffer is a queue of held words; mv says whether the head is presented.
   word_t mq[$];
   bit    mv;
   word_t md;
   bit    movf;

   function automatic void model_reset();
      mq.delete();
      mv   = 1'b0;
      md   = '0;
      movf = 1'b0;
   endfunction

   function automatic void model_edge(input bit we, input word_t wd, input bit rr, input bit fl);
      int pre;
      bit acc;
      bit ld;
      pre = mq.size();
      if (OVF_EN && we && pre == DEPTH) movf = 1'b1;
      if (fl) begin
         mq.delete();
         mv = 1'b0;
         md = '0;
         return;
      end
      acc = mv && rr;
      // A word can reach the head only once it sits in memory before the edge.
      ld  = (!mv || acc) && ((pre - int'(mv)) > 0);
      if (acc) void'(mq.pop_front());
      if (we && pre < DEPTH) mq.push_back(wd);
      mv = (mv && !acc) || ld;
      if (mv) md = mq[0];
   endfunction

   task automatic compare_model(input string tag);
      check({tag, ".count"}, word_t'(count), word_t'(mq.size()));
      check({tag, ".full"},  word_t'(full),  word_t'(mq.size() == DEPTH));
      check({tag, ".empty"}, word_t'(empty), word_t'(mq.size() == 0));
      check({tag, ".valid"}, word_t'(rd_valid), word_t'(mv));
      check({tag, ".ovf"},   word_t'(ovf),   word_t'(movf));
      if (mv) check({tag, ".data"}, rd_data, md);
   endtask

   // One clock with the given inputs; reports the word taken at this edge.
   task automatic step(input bit we, input word_t wd, input bit rr, input bit fl,
                       input string tag, output bit got, output word_t gw);
      wr_en    = we;
      wr_data  = wd;
      rd_ready = rr;
      flush    = fl;
      got      = rd_valid && rr && !fl;
      gw       = rd_data;
      @(posedge clk);
      #1;
      model_edge(we, wd, rr, fl);
      compare_model(tag);
   endtask

   task automatic do_reset();
      wr_en    = 1'b0;
      flush    = 1'b0;
      rd_ready = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      bit    we;
      word_t wd;
      bit    rr;
      bit    fl;
      int    ecnt;
      bit    ev;
      word_t ed;
   } vec_t;

   vec_t tbl[17];

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1);
   end

   initial begin
      bit    got;
      word_t gw;
      word_t in_w[600];
      int    out_idx;

      tbl[0]  = '{1'b1, 163'h1, 1'b0, 1'b0, 1, 1'b0, 163'h0};
      tbl[1]  = '{1'b0, 163'h0, 1'b0, 1'b0, 1, 1'b1, 163'h1};
      tbl[2]  = '{1'b0, 163'h0, 1'b1, 1'b0, 0, 1'b0, 163'h1};
      tbl[3]  = '{1'b1, 163'hA, 1'b0, 1'b0, 1, 1'b0, 163'h1};
      tbl[4]  = '{1'b1, 163'hB, 1'b0, 1'b0, 2, 1'b1, 163'hA};
      tbl[5]  = '{1'b1, 163'hC, 1'b0, 1'b0, 3, 1'b1, 163'hA};
      tbl[6]  = '{1'b0, 163'h0, 1'b0, 1'b0, 3, 1'b1, 163'hA};
      tbl[7]  = '{1'b0, 163'h0, 1'b1, 1'b0, 2, 1'b1, 163'hB};
      tbl[8]  = '{1'b0, 163'h0, 1'b1, 1'b0, 1, 1'b1, 163'hC};
      tbl[9]  = '{1'b0, 163'h0, 1'b1, 1'b0, 0, 1'b0, 163'hC};
      tbl[10] = '{1'b1, 163'hD, 1'b1, 1'b0, 1, 1'b0, 163'hC};
      tbl[11] = '{1'b1, 163'hE, 1'b1, 1'b0, 2, 1'b1, 163'hD};
      tbl[12] = '{1'b1, 163'hF, 1'b1, 1'b0, 2, 1'b1, 163'hE};
      tbl[13] = '{1'b0, 163'h0, 1'b1, 1'b0, 1, 1'b1, 163'hF};
      tbl[14] = '{1'b1, 163'h17, 1'b1, 1'b0, 1, 1'b0, 163'hF};
      tbl[15] = '{1'b0, 163'h0, 1'b0, 1'b0, 1, 1'b1, 163'h17};
      tbl[16] = '{1'b1, 163'h99, 1'b1, 1'b1, 0, 1'b0, 163'h0};

      // Reset state
      do_reset();
      #1;
      check("reset.count", word_t'(count), word_t'(0));
      check("reset.valid", word_t'(rd_valid), word_t'(0));
      check("reset.data",  rd_data, word_t'(0));
      check("reset.full",  word_t'(full), word_t'(0));
      check("reset.empty", word_t'(empty), word_t'(1));
      check("reset.ovf",   word_t'(ovf), word_t'(0));

      // Directed table: latency, hold-while-stalled, pop-to-empty, count==1 corner, flush
      for (int i = 0; i < 17; i++) begin
         wr_en    = tbl[i].we;
         wr_data  = tbl[i].wd;
         rd_ready = tbl[i].rr;
         flush    = tbl[i].fl;
         @(posedge clk);
         #1;
         check($sformatf("t%0d.count", i), word_t'(count), word_t'(tbl[i].ecnt));
         check($sformatf("t%0d.valid", i), word_t'(rd_valid), word_t'(tbl[i].ev));
         check($sformatf("t%0d.data", i),  rd_data, tbl[i].ed);
         check($sformatf("t%0d.empty", i), word_t'(empty), word_t'(tbl[i].ecnt == 0));
         $display("vec t%0d: we=%0b rr=%0b fl=%0b count=%0d valid=%0b data=%0h",
                  i, tbl[i].we, tbl[i].rr, tbl[i].fl, count, rd_valid, rd_data);
      end

      // Fill to DEPTH, overflow write, then drain in order
      do_reset();
      for (int i = 0; i < DEPTH; i++) step(1'b1, word_t'(i + 1), 1'b0, 1'b0, "fill", got, gw);
      check("fill.count", word_t'(count), word_t'(DEPTH));
      check("fill.full",  word_t'(full), word_t'(1));
      step(1'b1, word_t'(16'hDEAD), 1'b0, 1'b0, "ovfw", got, gw);
      check("ovfw.count", word_t'(count), word_t'(DEPTH));
      check("ovfw.full",  word_t'(full), word_t'(1));
      check("ovfw.ovf",   word_t'(ovf), word_t'(OVF_EN));
      $display("fill: wrote %0d words plus dropped 0xDEAD, count=%0d ovf=%0b", DEPTH, count, ovf);
      for (int i = 0; i < DEPTH; i++) begin
         step(1'b0, '0, 1'b1, 1'b0, "drain", got, gw);
         check($sformatf("drain%0d.got", i), word_t'(got), word_t'(1));
         if (got) check($sformatf("drain%0d.word", i), gw, word_t'(i + 1));
      end
      check("drain.empty", word_t'(empty), word_t'(1));
      $display("drain: %0d words checked in order", DEPTH);

      // Flush with count=5 and a simultaneous write; ovf must survive
      for (int i = 0; i < 5; i++) step(1'b1, rand_word(), 1'b0, 1'b0, "pre_flush", got, gw);
      check("pre_flush.count", word_t'(count), word_t'(5));
      step(1'b1, word_t'(16'hBEEF), 1'b1, 1'b1, "flush", got, gw);
      check("flush.count", word_t'(count), word_t'(0));
      check("flush.valid", word_t'(rd_valid), word_t'(0));
      check("flush.empty", word_t'(empty), word_t'(1));
      check("flush.ovf",   word_t'(ovf), word_t'(OVF_EN));
      $display("flush: count=%0d valid=%0b ovf=%0b", count, rd_valid, ovf);

      // Sustained write+pop every cycle for 600 words (pointers wrap twice)
      do_reset();
      out_idx = 0;
      for (int i = 0; i < 600; i++) in_w[i] = rand_word();
      for (int i = 0; i < 600; i++) begin
         step(1'b1, in_w[i], 1'b1, 1'b0, "thru", got, gw);
         if (got) begin
            check($sformatf("thru%0d.word", out_idx), gw, in_w[out_idx]);
            out_idx++;
         end
         if (i >= 1) check($sformatf("thru%0d.count", i), word_t'(count), word_t'(2));
      end
      for (int j = 0; j < 10 && out_idx < 600; j++) begin
         step(1'b0, '0, 1'b1, 1'b0, "thru_tail", got, gw);
         if (got) begin
            check($sformatf("thru%0d.word", out_idx), gw, in_w[out_idx]);
            out_idx++;
         end
      end
      check("thru.total", word_t'(out_idx), word_t'(600));
      $display("throughput: %0d words streamed", out_idx);

      // Randomized traffic against the reference model
      do_reset();
      begin
         int rr_pct[5] = '{10, 50, 95, 30, 60};
         for (int blk = 0; blk < 5; blk++) begin
            for (int c = 0; c < 700; c++) begin
               step($urandom_range(0, 99) < 60, rand_word(),
                    $urandom_range(0, 99) < rr_pct[blk],
                    $urandom_range(0, 499) == 0, "rand", got, gw);
            end
            $display("random block %0d: rd_ready %0d%%, count=%0d", blk, rr_pct[blk], count);
         end
      end

      // Asynchronous reset between clock edges in the middle of a burst
      do_reset();
      for (int i = 0; i < 4; i++) step(1'b1, rand_word(), 1'b0, 1'b0, "burst", got, gw);
      wr_en   = 1'b1;
      wr_data = rand_word();
      @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      check("arst.count", word_t'(count), word_t'(0));
      check("arst.valid", word_t'(rd_valid), word_t'(0));
      check("arst.data",  rd_data, word_t'(0));
      check("arst.empty", word_t'(empty), word_t'(1));
      check("arst.full",  word_t'(full), word_t'(0));
      model_reset();
      wr_en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      step(1'b1, word_t'(16'h5A5A), 1'b0, 1'b0, "post_rst_wr", got, gw);
      step(1'b0, '0, 1'b0, 1'b0, "post_rst_rd", got, gw);
      check("post_rst.data",  rd_data, word_t'(16'h5A5A));
      check("post_rst.valid", word_t'(rd_valid), word_t'(1));
      $display("async reset: first word after release = %0h", rd_data);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
